// File: rtl/digit_uart_tx.sv
// digit_uart_tx: streams a latched decimal digit vector as ASCII text
// over an 8N1 UART line, with an optional decimal point and CR LF.
module digit_uart_tx #(
  parameter int NUM_DIGITS   = 150,
  parameter int CLKS_PER_BIT = 868,
  parameter int DOT_AFTER    = 1,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [IW-1:0] IDX_END   = IW'(NUM_DIGITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_DIG  = 3'd2;
  localparam logic [2:0] S_DOT  = 3'd3;
  localparam logic [2:0] S_CR   = 3'd4;
  localparam logic [2:0] S_LF   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           sent_q, sent_d;
  logic [7:0]              chr_q, chr_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic                    tx_q, tx_d;

  logic       in_frame;
  logic       frame_end;
  logic [3:0] cur;
  logic [7:0] frame_chr;
  logic       tx_bit;

  assign tx   = tx_q;
  assign done = (state_q == S_FIN);
  assign busy = (state_q != S_IDLE) && (state_q != S_FIN);

  always_comb begin
    cur = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) cur = digits_q[4*i +: 4];
    end
  end

  always_comb begin
    in_frame  = state_q inside {S_DIG, S_DOT, S_CR, S_LF};
    frame_end = in_frame && (baud_q == BAUD_LAST) && (bit_q == 4'd9);
    frame_chr = chr_q;
    unique case (state_q)
      S_DOT:   frame_chr = 8'h2E;
      S_CR:    frame_chr = 8'h0D;
      S_LF:    frame_chr = 8'h0A;
      default: frame_chr = chr_q;
    endcase
    unique case (bit_q)
      4'd0:    tx_bit = 1'b0;
      4'd9:    tx_bit = 1'b1;
      default: tx_bit = frame_chr[3'(bit_q - 4'd1)];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    idx_d    = idx_q;
    sent_d   = sent_q;
    chr_d    = chr_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    // tx is registered from the current frame position, one clock behind it
    tx_d     = in_frame ? tx_bit : 1'b1;

    if (in_frame) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        bit_d  = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end

    unique case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          digits_d = digits;
          idx_d    = '0;
          sent_d   = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx_q == IDX_END) begin
          state_d = SEND_CRLF ? S_CR : S_FIN;
        end else if (cur > 4'd9) begin
          idx_d = idx_q + IW'(1);
        end else begin
          chr_d   = 8'h30 + {4'h0, cur};
          idx_d   = idx_q + IW'(1);
          state_d = S_DIG;
        end
      end
      S_DIG: begin
        if (frame_end) begin
          sent_d  = sent_q + IW'(1);
          state_d = S_SCAN;
          if ((DOT_AFTER != 0) && (int'(sent_d) == DOT_AFTER))
            state_d = S_DOT;
        end
      end
      S_DOT: if (frame_end) state_d = S_SCAN;
      S_CR:  if (frame_end) state_d = S_LF;
      S_LF:  if (frame_end) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      idx_q    <= '0;
      sent_q   <= '0;
      chr_q    <= 8'h00;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      idx_q    <= idx_d;
      sent_q   <= sent_d;
      chr_q    <= chr_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_digit_uart_tx.sv
// tb_digit_uart_tx: directed bench with a UART monitor decoding tx
// for a 4-digit, 4-clocks-per-bit build of digit_uart_tx.
module tb_digit_uart_tx;

  localparam int ND  = 4;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        tx;
  logic        busy;
  logic        done;

  digit_uart_tx #(
    .NUM_DIGITS  (ND),
    .CLKS_PER_BIT(CPB),
    .DOT_AFTER   (1),
    .SEND_CRLF   (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .digits(digits),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int lat, blo, dc;

  logic [7:0] rx[$];
  int unstable = 0;
  int first_fall = -1;

  // monitor: frame starts on the first low sample, 4 samples per bit
  initial begin
    logic [9:0] bv;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        if (first_fall < 0) first_fall = cyc;
        bv = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bv[b] = tx;
            else if (tx !== bv[b]) unstable++;
          end
        end
        if (bv[0] !== 1'b0 || bv[9] !== 1'b1) unstable++;
        rx.push_back(bv[8:1]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_text(input string tag, input string s);
    chk({tag, "_len"}, rx.size(), s.len());
    for (int i = 0; i < s.len(); i++)
      if (i < rx.size()) chk({tag, "_chr"}, rx[i], s[i]);
  endtask

  task automatic clear_mon();
    rx.delete();
    unstable = 0;
    first_fall = -1;
  endtask

  // call at a negedge; k = acceptance edge
  task automatic launch(input logic [15:0] d);
    digits = d;
    start  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int bl);
    l  = -1;
    bl = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        l = cyc - k;
        break;
      end
      if (busy !== 1'b1) bl++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // slots 2,7,1,8
    clear_mon();
    launch(16'h8172);
    wait_done(lat, blo);
    chk("lat_2718", lat, 285);
    chk("busy_2718", blo, 0);
    repeat (20) @(negedge clk);
    chk_text("t2718", "2.718\r\n");
    chk("fall_2718", first_fall - k, 2);
    chk("bits_2718", unstable, 0);
    chk("donecnt_2718", done_cnt, 1);

    // leading blanks
    clear_mon();
    launch(16'h13FF);
    wait_done(lat, blo);
    chk("lat_ff31", lat, 205);
    chk("busy_ff31", blo, 0);
    repeat (20) @(negedge clk);
    chk_text("tff31", "3.1\r\n");
    chk("fall_ff31", first_fall - k, 4);
    chk("bits_ff31", unstable, 0);

    // all blank
    clear_mon();
    dc = done_cnt;
    launch(16'hFFFF);
    wait_done(lat, blo);
    chk("lat_blank", lat, 85);
    repeat (20) @(negedge clk);
    chk_text("tblank", "\r\n");
    chk("fall_blank", first_fall - k, 6);
    chk("donecnt_blank", done_cnt - dc, 1);

    // start while busy ignored, start in done cycle accepted
    clear_mon();
    launch(16'h8172);
    repeat (100) @(negedge clk);
    digits = 16'h9999;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, blo);
    chk("lat_ign", lat, 285);
    chk("busy_ign", blo, 0);
    launch(16'h13FF);
    chk_text("tign", "2.718\r\n");
    clear_mon();
    wait_done(lat, blo);
    chk("lat_chain", lat, 205);
    repeat (20) @(negedge clk);
    chk_text("tchain", "3.1\r\n");
    chk("fall_chain", first_fall - k, 4);

    // reset during data bit 0 of the dot
    clear_mon();
    launch(16'h8172);
    repeat (49) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    rst = 1'b1;
    dc  = done_cnt;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_nodone", done_cnt - dc, 0);
    clear_mon();
    launch(16'h8172);
    wait_done(lat, blo);
    chk("lat_after", lat, 285);
    repeat (20) @(negedge clk);
    chk_text("tafter", "2.718\r\n");
    chk("bits_after", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_uart_tx.md
Name: digit_uart_tx

Overview:
- Downstream stage of the decimal converter (convert_to_10).
- Takes the converter's decimal digit vector after its done pulse and streams it as ASCII text over a UART TX line, 8N1, LSB first.
- Inserts a decimal point after the integer part and ends the line with CR LF, so the board prints e = "2.718..." on a serial terminal.

Parameters:
- NUM_DIGITS, 150: number of 4-bit digit slots in the input vector.
- CLKS_PER_BIT, 868: clocks per UART bit (100 MHz / 115200); legal range >= 2.
- DOT_AFTER, 1: a '.' (0x2E) is sent after this many digits have been sent; 0 = no dot.
- SEND_CRLF, 1: 1 = append 0x0D, 0x0A after the last digit; 0 = no line end.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- digits  in  4*NUM_DIGITS  slot i = digits[4*i+3:4*i]; slot 0 is most significant and is sent first; a value >9 means blank.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from the cycle after acceptance until transmission ends.
- done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset:
  - tx=1, busy=0, done=0; FSM goes to IDLE; all counters cleared.
  - Reset asserted mid-frame aborts the transfer: tx=1 at the next edge and no done pulse.
- IDLE: on a start sample, latch digits into an internal register, clear the digit index and the sent-digit count, go to SCAN; busy=1 from the next cycle.
- Changes on the digits input after acceptance have no effect.
- start while busy=1 is ignored. start in the same cycle as done is accepted, because busy is already 0.
- SCAN (one slot per clock):
  - If index = NUM_DIGITS: go to CR if SEND_CRLF=1, else FINISH.
  - Else if the slot is blank: increment index and stay in SCAN.
  - Else: load char = 0x30 + digit, increment index, go to SEND.
- SEND: one 8N1 frame of 10*CLKS_PER_BIT cycles:
  - start bit 0, then data bits 0..7, then stop bit 1; each bit is held exactly CLKS_PER_BIT cycles.
  - A baud counter runs 0..CLKS_PER_BIT-1 and a bit counter runs 0..9.
- Frame end:
  - After a digit frame, increment the sent count. If DOT_AFTER!=0 and the count equals DOT_AFTER, go to SEND with 0x2E (the dot is sent only once). Otherwise return to SCAN.
  - After the dot frame, return to SCAN.
- CR and LF are sent as frames 0x0D then 0x0A, then go to FINISH.
- FINISH: done=1 and busy=0 in the same cycle; return to IDLE. tx stays 1.
- Latency:
  - Acceptance edge k; SCAN evaluates slot 0 at edge k+1; tx falls at edge k+2+B, where B = number of leading blank slots.
  - Consecutive characters are back-to-back: each stop bit is followed directly by the next start bit, except for one SCAN clock per slot examined between digit frames (tx=1 during those clocks).
- Boundaries:
  - All slots blank: no digits and no dot; only CR LF is sent (or done follows the scan if SEND_CRLF=0).
  - Fewer valid digits than DOT_AFTER: no dot is sent.
  - The last slot valid and equal to the DOT_AFTER-th digit: the dot is still sent before CR.
- Widths:
  - Index width is clog2(NUM_DIGITS+1).
  - Baud counter width is clog2(CLKS_PER_BIT).
  - The ASCII add is 8-bit; digits >9 never reach the add.

Test Plan:
- NUM_DIGITS=4, CLKS_PER_BIT=4, digits slots = 2,7,1,8; pulse start -> the UART monitor decodes "2.718\r\n" (0x32,0x2E,0x37,0x31,0x38,0x0D,0x0A); done pulses exactly once; busy is high throughout; each bit lasts 4 clocks.
- Same config, slots = F,F,3,1 -> first tx fall at acceptance+4 clocks; text "3.1\r\n".
- All slots = F -> text "\r\n" only; done follows; no dot.
- start pulsed again mid-transfer with different digits -> ignored; output unchanged; a start in the done cycle begins a new transfer at once.
- rst asserted during a data bit of the 2nd character -> tx=1 and busy=0 next cycle, no done; a new start afterwards sends the full string correctly.
- Full config (150 digits, CLKS_PER_BIT=4) fed from e_calc + convert_to_10 -> the decoded string starts "2.71828182845904523536" and ends "\r\n".
